fifo_burst_reader: RTL and testbench

- Read-side consumer for the team's dual-clock FIFO. Sits entirely in the FIFO read clock domain.
- Drains the FIFO (showahead mode) into a registered valid/ready stream grouped into bursts.
- Each burst is framed with sop_o/eop_o.
- A burst starts when BURST_LEN words are available, or when a timeout expires with a partial amount pending.

---
 rtl/fifo_burst_reader.sv | 169 ++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer for the dual-clock FIFO (showahead), framing bursts with sop/eop.
// Optional statistics counters are enabled with FIFO_BURST_READER_STATS_EN.
module fifo_burst_reader #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned AWIDTH    = 4,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              aclr_i,
  input  logic              rd_empty_i,
  input  logic [AWIDTH-1:0] rd_usedw_i,
  input  logic [DWIDTH-1:0] q_i,
  output logic              rd_req_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sop_o,
  output logic              eop_o,
`ifdef FIFO_BURST_READER_STATS_EN
  output logic [15:0]       burst_cnt_o,
  output logic [15:0]       timeout_cnt_o,
`endif
  output logic              busy_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam int unsigned RemW = AWIDTH + 1;
  localparam logic [RemW-1:0] BurstLen    = RemW'(BURST_LEN);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic              first_q, first_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic [RemW-1:0]   lvl;
  logic              full_avail;
  logic              pop;
  logic              accept;
  logic              timeout_start;

  // usedw wraps to 0 when the FIFO is completely full
  always_comb begin
    lvl = {1'b0, rd_usedw_i};
    if ((rd_usedw_i == '0) && !rd_empty_i) lvl = {1'b1, {AWIDTH{1'b0}}};
  end

  assign full_avail = (lvl >= BurstLen);
  assign accept     = valid_q & ready_i;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    first_d       = first_q;
    pop           = 1'b0;
    timeout_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (full_avail) begin
          state_d = StBurst;
          rem_d   = BurstLen;
          first_d = 1'b1;
        end else if (!rd_empty_i) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (rd_empty_i) begin
          state_d = StIdle;
        end else if (full_avail) begin
          state_d = StBurst;
          rem_d   = BurstLen;
          first_d = 1'b1;
        end else if (cnt_q == TimeoutLast) begin
          state_d       = StBurst;
          rem_d         = lvl;
          first_d       = 1'b1;
          timeout_start = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBurst: begin
        // Pop only once the output register is free or being drained this cycle
        pop = (rem_q != '0) & ~rd_empty_i & (~valid_q | ready_i);
        if (pop) begin
          rem_d   = rem_q - RemW'(1);
          first_d = 1'b0;
          if (rem_q == RemW'(1)) state_d = StIdle;
        end else if (rem_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (pop) begin
      data_d  = q_i;
      valid_d = 1'b1;
      sop_d   = first_q;
      eop_d   = (rem_q == RemW'(1));
    end else if (accept) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge aclr_i) begin
    if (!aclr_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign rd_req_o = pop;
  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign sop_o    = sop_q;
  assign eop_o    = eop_q;
  assign busy_o   = (state_q != StIdle) | valid_q;

`ifdef FIFO_BURST_READER_STATS_EN
  logic [15:0] burst_cnt_q, timeout_cnt_q;

  always_ff @(posedge clk_i or negedge aclr_i) begin
    if (!aclr_i) begin
      burst_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (accept && eop_q && (burst_cnt_q != 16'hFFFF)) burst_cnt_q <= burst_cnt_q + 16'd1;
      if (timeout_start && (timeout_cnt_q != 16'hFFFF)) timeout_cnt_q <= timeout_cnt_q + 16'd1;
    end
  end

  assign burst_cnt_o   = burst_cnt_q;
  assign timeout_cnt_o = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a queue-based showahead FIFO model.
// Stats checks run only when FIFO_BURST_READER_STATS_EN is defined.
module tb_fifo_burst_reader;

  localparam int unsigned AW = 4;

  logic        clk = 1'b0;
  logic        aclr;
  logic        rd_empty;
  logic [AW-1:0] rd_usedw;
  logic [7:0]  q;
  logic        rd_req;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        sop;
  logic        eop;
  logic        busy;
`ifdef FIFO_BURST_READER_STATS_EN
  logic [15:0] burst_cnt;
  logic [15:0] timeout_cnt;
`endif

  fifo_burst_reader #(
    .DWIDTH   (8),
    .AWIDTH   (AW),
    .BURST_LEN(4),
    .TIMEOUT  (16)
  ) dut (
    .clk_i        (clk),
    .aclr_i       (aclr),
    .rd_empty_i   (rd_empty),
    .rd_usedw_i   (rd_usedw),
    .q_i          (q),
    .rd_req_o     (rd_req),
    .data_o       (data),
    .valid_o      (valid),
    .ready_i      (ready),
    .sop_o        (sop),
    .eop_o        (eop),
`ifdef FIFO_BURST_READER_STATS_EN
    .burst_cnt_o  (burst_cnt),
    .timeout_cnt_o(timeout_cnt),
`endif
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  logic [7:0]  fq[$];
  logic [9:0]  rx[$];
  int          pops;
  logic        last_pop;
  int          vectors = 0;
  int          errors  = 0;
  logic [20:0] mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_drive();
    rd_empty = (fq.size() == 0);
    rd_usedw = AW'(fq.size());
    q        = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    fifo_drive();
  endtask

  // Sample pop/handshake mid-cycle, then apply the FIFO pop after the edge
  task automatic tick();
    logic p;
    @(negedge clk);
    p = rd_req;
    if (valid && ready) rx.push_back({sop, eop, data});
    @(posedge clk);
    #1;
    last_pop = p;
    if (p && fq.size() != 0) begin
      void'(fq.pop_front());
      pops++;
      fifo_drive();
    end
    #1;
  endtask

  initial begin
    aclr  = 1'b0;
    ready = 1'b1;
    pops  = 0;
    last_pop = 1'b0;
    fifo_drive();
    #12;
    check("rst_valid", valid, 0);
    check("rst_sop", sop, 0);
    check("rst_eop", eop, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_rdreq", rd_req, 0);
    @(posedge clk);
    #2;
    aclr = 1'b1;

    // Full burst, ready held high
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    pops = 0; rx.delete();
    tick();
    check("t1_req_first", rd_req, 1);
    check("t1_busy", busy, 1);
    check("t1_valid0", valid, 0);
    tick(); check("t1_b0", {sop, eop, data}, 10'h2A0); check("t1_req1", rd_req, 1);
    tick(); check("t1_b1", {sop, eop, data}, 10'h0A1); check("t1_req2", rd_req, 1);
    tick(); check("t1_b2", {sop, eop, data}, 10'h0A2); check("t1_req3", rd_req, 1);
    tick(); check("t1_b3", {sop, eop, data}, 10'h1A3); check("t1_req_end", rd_req, 0);
    tick();
    check("t1_valid_end", valid, 0);
    check("t1_busy_end", busy, 0);
    check("t1_pops", pops, 4);
    check("t1_rx", rx.size(), 4);

    // Partial burst forced by timeout
    push(8'hB0); push(8'hB1);
    pops = 0; rx.delete();
    repeat (16) tick();
    check("t2_req_early", rd_req, 0);
    tick();
    check("t2_nopop", pops, 0);
    check("t2_req_timeout", rd_req, 1);
    tick(); check("t2_b0", {sop, eop, data}, 10'h2B0);
    tick(); check("t2_b1", {sop, eop, data}, 10'h1B1);
    tick();
    check("t2_valid_end", valid, 0);
    check("t2_busy_end", busy, 0);

    // Backpressure 1,0,0,1
    push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
    pops = 0; rx.delete();
    tick(); tick();
    check("t3_b0", {sop, eop, data}, 10'h2C0);
    ready = 1'b0;
    tick();
    check("t3_stall1", {valid, sop, eop, data}, 11'h6C0);
    check("t3_stall1_req", rd_req, 0);
    tick();
    check("t3_stall2", {valid, sop, eop, data}, 11'h6C0);
    check("t3_stall_pops", pops, 1);
    ready = 1'b1;
    repeat (5) tick();
    check("t3_pops", pops, 4);
    check("t3_rx", rx.size(), 4);
    if (rx.size() == 4) begin
      check("t3_rx0", rx[0], 10'h2C0);
      check("t3_rx1", rx[1], 10'h0C1);
      check("t3_rx2", rx[2], 10'h0C2);
      check("t3_rx3", rx[3], 10'h1C3);
    end
    check("t3_valid_end", valid, 0);

    // FIFO completely full: four back-to-back bursts
    for (int i = 0; i < 16; i++) push(8'(8'h50 + i));
    check("t4_usedw_wrap", rd_usedw, 0);
    pops = 0; rx.delete(); mask = '0;
    for (int k = 0; k < 21; k++) begin
      tick();
      mask[k] = last_pop;
    end
    check("t4_popmask", mask, 21'b0_1111_0_1111_0_1111_0_1111_0);
    check("t4_fifo_empty", fq.size(), 0);
    check("t4_rx", rx.size(), 16);
    if (rx.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check("t4_beat", rx[i], {(i % 4) == 0, (i % 4) == 3, 8'(8'h50 + i)});
      end
    end
    check("t4_valid_end", valid, 0);

    // Reset after the second beat of a burst
    push(8'hE0); push(8'hE1); push(8'hE2); push(8'hE3);
    tick(); tick(); tick();
    check("t5_b1", {sop, eop, data}, 10'h0E1);
    aclr = 1'b0;
    #1;
    check("t5_rst_valid", valid, 0);
    check("t5_rst_req", rd_req, 0);
    check("t5_rst_busy", busy, 0);
    tick();
    aclr = 1'b1;
    check("t5_fifo_left", fq.size(), 2);
    push(8'hF0); push(8'hF1);
    rx.delete();
    tick();
    check("t5_req", rd_req, 1);
    tick();
    check("t5_b0", {sop, eop, data}, 10'h2E2);
    repeat (4) tick();
    check("t5_rx", rx.size(), 4);
    if (rx.size() == 4) check("t5_last", rx[3], 10'h1F1);
    check("t5_valid_end", valid, 0);

    // Single-word partial burst
    push(8'h77);
    repeat (17) tick();
    check("t6_req", rd_req, 1);
    tick();
    check("t6_beat", {valid, sop, eop, data}, 11'h777);
    tick();
    check("t6_valid_end", valid, 0);

`ifdef FIFO_BURST_READER_STATS_EN
    aclr = 1'b0;
    tick();
    aclr = 1'b1;
    check("st_rst_burst", burst_cnt, 0);
    check("st_rst_timeout", timeout_cnt, 0);
    push(8'h01); push(8'h02);
    repeat (20) tick();
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    repeat (6) tick();
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    repeat (6) tick();
    check("st_burst_cnt", burst_cnt, 3);
    check("st_timeout_cnt", timeout_cnt, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
